sonar_tof_capture: RTL and testbench
====================================

Name: sonar_tof_capture

Overview:
- Downstream consumer of the SonarOnChip datapath comparator output (cmp).
- Measures echo time-of-flight as a count of ce_pcm ticks from the end of a mclear pulse (transmit/measurement start) to the first debounced cmp assertion.
- Applies a blanking window to reject transmit ringing and a timeout for no-echo cases.
- Presents the result to the wishbone register logic through a valid/ack handshake.

Parameters:
- CNT_W, 16, width of the tick counter and result.
- BLANK_TICKS, 8, number of ce_pcm ticks after start during which cmp is ignored. Legal range 0..TIMEOUT-1.
- DEBOUNCE, 3, number of consecutive ce_pcm ticks with cmp=1 required for detection. Minimum 1.
- TIMEOUT, 1000, tick count at which the measurement aborts. Must be greater than BLANK_TICKS and at most 2^CNT_W-1.

Ports:
- wb_clk_i  in  1  single system clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- ce_pcm  in  1  PCM-rate clock enable, one wb_clk_i cycle wide.
- mclear  in  1  level start/re-arm. While high, the measurement is held at start. Counting begins on ticks after it falls.
- cmp  in  1  comparator output from the datapath, synchronous to wb_clk_i.
- ack_i  in  1  consumer has read the result. Clears valid_o.
- tof_o  out  CNT_W  captured tick index of the echo, or all-ones on timeout.
- valid_o  out  1  result available.
- timeout_o  out  1  result is a timeout (qualified by valid_o).
- busy_o  out  1  measurement in progress (state BLANK or LISTEN).

Behaviour:
- Reset (wb_rst_i=1, synchronous) sets: state=IDLE, count=0, run=0, cand=0, tof_o=0, valid_o=0, timeout_o=0, busy_o=0.
- State encoding: IDLE, BLANK, LISTEN, DONE.
- busy_o is registered and equals 1 exactly in BLANK or LISTEN.
- mclear=1 (any state, not in reset), each cycle:
  - state<=BLANK, count<=0, run<=0.
  - valid_o<=0, timeout_o<=0.
  - tof_o holds its value.
  - ce_pcm is ignored.
  - mclear has priority over ack_i and over all tick events.
- Tick processing applies only on cycles with ce_pcm=1 and mclear=0, in BLANK or LISTEN:
  - The sampled index i is the current count; then count<=count+1.
  - The first tick after mclear falls is therefore i=0.
- BLANK: cmp is ignored. On the tick with i==BLANK_TICKS-1, go to LISTEN. If BLANK_TICKS=0, enter LISTEN directly from mclear release, with the same cycle semantics.
- LISTEN, cmp=1 on a tick:
  - If run==0, cand<=i.
  - run<=run+1.
  - When run+1==DEBOUNCE:
    - state<=DONE, valid_o<=1, timeout_o<=0.
    - tof_o<=(run==0 ? i : cand).
- LISTEN, cmp=0 on a tick: run<=0.
- Timeout: on a LISTEN tick with i==TIMEOUT-1 and no detection completing that tick:
  - state<=DONE, valid_o<=1, timeout_o<=1, tof_o<=all-ones.
  - If detection completes on the same tick, detection wins.
- Result latency: valid_o rises on the wb_clk_i cycle after the deciding tick cycle.
- DONE:
  - Holds tof_o, valid_o and timeout_o; further ce_pcm and cmp are ignored.
  - ack_i=1 clears valid_o and timeout_o and goes to IDLE; tof_o keeps the last value.
  - ack_i in any state other than DONE has no effect.
- IDLE: ignores ce_pcm and cmp and waits for mclear.
- The counter never wraps, because TIMEOUT bounds it.
- Reset asserted mid-measurement aborts to reset values with no result.

Decomposition:
- Shared package sonar_pkg holds:
  - the state enum (IDLE/BLANK/LISTEN/DONE);
  - default constants TOF_CNT_W=16, TOF_BLANK=8, TOF_DEBOUNCE=3, TOF_TIMEOUT=1000.
- One natural sub-module: sonar_debounce (run counter plus cand latch, taking tick, cmp, clear and index; producing detect and captured index). The FSM and counter stay in the top.

Test Plan:
- Echo detect: pulse mclear 1 cycle; cmp=1 for ticks 50..60 -> valid_o=1 one cycle after tick 52, tof_o=50, timeout_o=0, busy_o=0.
- Blanking: cmp=1 ticks 2..6, then cmp=1 from tick 30 -> tof_o=30.
- Debounce glitch: cmp=1 ticks 20,21, 0 at 22, 1 from 40 -> tof_o=40.
- Timeout: cmp=0 throughout -> valid_o=1 after tick 999, timeout_o=1, tof_o=16'hFFFF. ack_i pulse -> valid_o=0, timeout_o=0, state IDLE.
- Re-arm and priority:
  - mclear mid-LISTEN at tick 100 -> count restarts; echo at new tick 25 gives tof_o=25.
  - mclear and ack_i together in DONE -> valid_o=0, state BLANK.
- Reset: assert wb_rst_i in LISTEN -> all outputs 0 next cycle; no valid_o until a new mclear.

Source files
------------

// File: rtl/sonar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sonar_pkg : shared types and default constants for sonar ToF capture       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package sonar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_LISTEN = 2'd2,
    ST_DONE   = 2'd3
  } tof_state_t;

  localparam int TOF_CNT_W    = 16;
  localparam int TOF_BLANK    = 8;
  localparam int TOF_DEBOUNCE = 3;
  localparam int TOF_TIMEOUT  = 1000;

endpackage
`default_nettype wire

// File: rtl/sonar_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sonar_debounce : consecutive-tick run counter with first-tick index latch  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sonar_debounce #(
  parameter int CNT_W    = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_cmp,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_idx,
  output logic             o_detect,
  output logic [CNT_W-1:0] o_cap_idx
);

  localparam logic [CNT_W-1:0] c_DEBOUNCE = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_cand;
  logic [CNT_W-1:0] w_run_inc;

  assign w_run_inc = r_run + 1'b1;
  assign o_detect  = i_tick & i_cmp & (w_run_inc == c_DEBOUNCE);
  // A run of length one has not latched its start yet, so bypass the latch.
  assign o_cap_idx = (r_run == '0) ? i_idx : r_cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= '0;
      r_cand <= '0;
    end else if (i_clear) begin
      r_run  <= '0;
    end else if (i_tick) begin
      if (i_cmp) begin
        if (r_run == '0) r_cand <= i_idx;
        r_run <= w_run_inc;
      end else begin
        r_run <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sonar_tof_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sonar_tof_capture : echo time-of-flight capture with blanking and timeout  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sonar_tof_capture
  import sonar_pkg::*;
#(
  parameter int CNT_W       = TOF_CNT_W,
  parameter int BLANK_TICKS = TOF_BLANK,
  parameter int DEBOUNCE    = TOF_DEBOUNCE,
  parameter int TIMEOUT     = TOF_TIMEOUT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ce_pcm,
  input  logic             mclear,
  input  logic             cmp,
  input  logic             ack_i,
  output logic [CNT_W-1:0] tof_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] c_BLANK_LAST =
    CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);
  // With no blanking, release from mclear lands straight in LISTEN.
  localparam tof_state_t c_START = (BLANK_TICKS == 0) ? ST_LISTEN : ST_BLANK;

  tof_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_tof;
  logic             r_valid;
  logic             r_timeout;
  logic             r_busy;

  logic             w_listen_tick;
  logic             w_detect;
  logic [CNT_W-1:0] w_cap_idx;

  assign w_listen_tick = ce_pcm & ~mclear & (r_state == ST_LISTEN);

  sonar_debounce #(
    .CNT_W    (CNT_W),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .i_tick    (w_listen_tick),
    .i_cmp     (cmp),
    .i_clear   (mclear),
    .i_idx     (r_count),
    .o_detect  (w_detect),
    .o_cap_idx (w_cap_idx)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_tof     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else if (mclear) begin
      r_state   <= c_START;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (ce_pcm) begin
            r_count <= r_count + 1'b1;
            if (r_count == c_BLANK_LAST) r_state <= ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          if (ce_pcm) begin
            r_count <= r_count + 1'b1;
            if (w_detect) begin
              r_state   <= ST_DONE;
              r_tof     <= w_cap_idx;
              r_valid   <= 1'b1;
              r_timeout <= 1'b0;
              r_busy    <= 1'b0;
            end else if (r_count == c_TO_LAST) begin
              r_state   <= ST_DONE;
              r_tof     <= '1;
              r_valid   <= 1'b1;
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (ack_i) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tof_o     = r_tof;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;
  assign busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sonar_tof_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sonar_tof_capture : scoreboard bench for sonar_tof_capture              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_sonar_tof_capture;

  typedef struct {
    logic [15:0] tof;
    logic        to;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ce, mclear, cmp, ack;
  logic [15:0] tof;
  logic        valid, timeout, busy;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  sonar_tof_capture #(
    .CNT_W(16), .BLANK_TICKS(8), .DEBOUNCE(3), .TIMEOUT(1000)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .ce_pcm    (ce),
    .mclear    (mclear),
    .cmp       (cmp),
    .ack_i     (ack),
    .tof_o     (tof),
    .valid_o   (valid),
    .timeout_o (timeout),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising valid_o is matched against the oldest expectation.
  always @(negedge clk) begin
    if (valid === 1'b1 && prev_v === 1'b0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("tof", 32'(tof), 32'(e.tof));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("busy_at_valid", 32'(busy), 32'd0);
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_v = valid;
  end

  task automatic pulse_mclear();
    @(negedge clk); mclear = 1'b1;
    @(negedge clk); mclear = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  // One tick per two clocks; cmp high inside either range; expectation pushed on the deciding tick.
  task automatic run_ticks(input int n, input int a0, input int a1, input int b0, input int b1,
                           input int dec, input logic [15:0] etof, input logic eto);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce  = 1'b1;
      cmp = ((i >= a0) && (i <= a1)) || ((i >= b0) && (i <= b1));
      if (i == dec) sb_q.push_back('{tof: etof, to: eto, cyc: cyc + 1});
      @(negedge clk);
      ce  = 1'b0;
      cmp = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; mclear = 1'b0; cmp = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tof", 32'(tof), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Idle ignores ticks and cmp.
    run_ticks(5, 0, 4, -1, -1, -1, 16'h0, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic echo at 50..60.
    pulse_mclear();
    chk("busy_after_mclear", 32'(busy), 32'd1);
    run_ticks(61, 50, 60, -1, -1, 52, 16'd50, 1'b0);
    chk("done_hold_valid", 32'(valid), 32'd1);
    chk("done_hold_tof", 32'(tof), 32'd50);
    pulse_ack();
    chk("ack_valid", 32'(valid), 32'd0);
    chk("ack_tof_kept", 32'(tof), 32'd50);

    // Blanking rejects ringing at 2..6.
    pulse_mclear();
    run_ticks(40, 2, 6, 30, 39, 32, 16'd30, 1'b0);
    pulse_ack();

    // Last blanked tick is 7; first listened tick is 8.
    pulse_mclear();
    run_ticks(20, 7, 19, -1, -1, 10, 16'd8, 1'b0);
    pulse_ack();

    // Two-tick glitch does not detect.
    pulse_mclear();
    run_ticks(50, 20, 21, 40, 49, 42, 16'd40, 1'b0);
    pulse_ack();

    // Timeout with no echo.
    pulse_mclear();
    run_ticks(1000, -1, -1, -1, -1, 999, 16'hFFFF, 1'b1);
    chk("to_timeout_hold", 32'(timeout), 32'd1);
    pulse_ack();
    chk("to_ack_valid", 32'(valid), 32'd0);
    chk("to_ack_timeout", 32'(timeout), 32'd0);
    chk("to_ack_busy", 32'(busy), 32'd0);
    run_ticks(3, 0, 2, -1, -1, -1, 16'h0, 1'b0);
    chk("idle_after_ack_busy", 32'(busy), 32'd0);

    // Re-arm mid-LISTEN restarts the count.
    pulse_mclear();
    run_ticks(100, -1, -1, -1, -1, -1, 16'h0, 1'b0);
    chk("listen_busy", 32'(busy), 32'd1);
    pulse_mclear();
    run_ticks(30, 25, 29, -1, -1, 27, 16'd25, 1'b0);

    // mclear beats ack in DONE.
    @(negedge clk); mclear = 1'b1; ack = 1'b1;
    @(negedge clk); mclear = 1'b0; ack = 1'b0;
    chk("prio_valid", 32'(valid), 32'd0);
    chk("prio_busy", 32'(busy), 32'd1);
    chk("prio_tof_kept", 32'(tof), 32'd25);
    run_ticks(20, 15, 19, -1, -1, 17, 16'd15, 1'b0);
    pulse_ack();

    // Reset mid-LISTEN aborts with no result.
    pulse_mclear();
    run_ticks(20, -1, -1, -1, -1, -1, 16'h0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_tof", 32'(tof), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    run_ticks(10, 0, 9, -1, -1, -1, 16'h0, 1'b0);
    chk("midrst_no_valid", 32'(valid), 32'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
